imm_rot_encoder: RTL

//  Inverse of the execute-stage Val2 immediate decode. The decode rule is
//  Val2 = ROR(sext32(imm8), 2*rot), with shift_operand = {rot[3:0], imm8[7:0]}.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/imm_rot_check.sv | 24 ++
 rtl/imm_rot_encoder.sv | 105 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants: operand/immediate field widths, encoder FSM state codes
// and the packed result payload.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ROT_W  = 4;
  localparam int unsigned IMM_W  = 8;
  localparam int unsigned SHOP_W = ROT_W + IMM_W;
  localparam int unsigned TRY_W  = ROT_W + 1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SEARCH = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  typedef struct packed {
    logic              encodable;
    logic [SHOP_W-1:0] shift_op;
    logic [TRY_W-1:0]  rot_tries;
  } enc_result_t;

endpackage

// File: rtl/imm_rot_check.sv
// Single-rotate candidate test: rotates value left by 2*rot and reports whether
// the result is a sign-extended 8-bit immediate.
module imm_rot_check
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic [ROT_W-1:0]  rot,
  output logic              hit,
  output logic [IMM_W-1:0]  imm8
);

  logic [ROT_W:0]      w_sh;
  logic [2*DATA_W-1:0] w_dbl;
  logic [DATA_W-1:0]   w_rol;

  // Upper half of the doubled word shifted left is the rotate-left; 2*rot never exceeds 30.
  assign w_sh  = {rot, 1'b0};
  assign w_dbl = {value, value} << w_sh;
  assign w_rol = w_dbl[2*DATA_W-1:DATA_W];

  assign hit  = (w_rol[DATA_W-1:IMM_W] == {(DATA_W-IMM_W){w_rol[IMM_W-1]}});
  assign imm8 = w_rol[IMM_W-1:0];

endmodule

// File: rtl/imm_rot_encoder.sv
// Finds the lowest {rot, imm8} whose decode ROR(sext(imm8), 2*rot) reproduces
// a 32-bit constant, evaluating one rotate per clock.
module imm_rot_encoder
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              encodable,
  output logic [SHOP_W-1:0] shift_op,
  output logic [TRY_W-1:0]  rot_tries
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_value;
  logic [ROT_W-1:0]  r_rot;
  enc_result_t       r_res;
  enc_result_t       w_res_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              w_in_ready_nxt;
  logic              w_out_valid_nxt;
  logic              w_hit;
  logic [IMM_W-1:0]  w_imm8;
  logic              w_last_rot;
  logic              w_accept;

  imm_rot_check u_check (
    .value (r_value),
    .rot   (r_rot),
    .hit   (w_hit),
    .imm8  (w_imm8)
  );

  assign w_last_rot = (r_rot == {ROT_W{1'b1}});
  assign w_accept   = (r_state == ST_IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (in_valid)             w_state_nxt = ST_SEARCH;
      ST_SEARCH: if (w_hit || w_last_rot)  w_state_nxt = ST_DONE;
      ST_DONE:   if (out_ready)            w_state_nxt = ST_IDLE;
      default:                             w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; the result is loaded once, on leaving SEARCH.
  always_comb begin
    w_in_ready_nxt  = (w_state_nxt == ST_IDLE);
    w_out_valid_nxt = (w_state_nxt == ST_DONE);
    w_res_nxt       = r_res;
    if (r_state == ST_SEARCH) begin
      if (w_hit) begin
        w_res_nxt.encodable = 1'b1;
        w_res_nxt.shift_op  = {r_rot, w_imm8};
        w_res_nxt.rot_tries = TRY_W'(r_rot) + TRY_W'(1);
      end else if (w_last_rot) begin
        w_res_nxt.encodable = 1'b0;
        w_res_nxt.shift_op  = '0;
        w_res_nxt.rot_tries = TRY_W'(2 ** ROT_W);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_value     <= '0;
      r_rot       <= '0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_res       <= w_res_nxt;
      if (w_accept) begin
        r_value <= value;
        r_rot   <= '0;
      end else if ((r_state == ST_SEARCH) && !w_hit && !w_last_rot) begin
        r_rot <= r_rot + ROT_W'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign encodable = r_res.encodable;
  assign shift_op  = r_res.shift_op;
  assign rot_tries = r_res.rot_tries;

endmodule
